// File: rtl/riscv_defines.sv
// Shared instruction-memory types: instruction word, NOP encoding, default depth
// and the loader state encoding.
package riscv_defines;

    typedef logic [31:0] inst_t;

    localparam inst_t INST_NOP  = 32'h0000_0013;
    localparam int    IMEM_WORD = 1024;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } imem_ld_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader: assembles little-endian words from the program byte stream
// and issues one write strobe per completed in-range word.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  LD_IDLE | waiting for prog_start; bytes are ignored
//  LD_LOAD | collecting bytes into lanes 0..3, writing a word on lane 3
//  LD_DONE | last word written, prog_done asserted for this one cycle
module imem_loader
    import riscv_defines::*;
#(
    parameter int DEPTH_WORDS = IMEM_WORD
) (
    input  logic        clk,
    input  logic        start,
    input  logic        prog_start,
    input  logic [31:0] prog_base,
    input  logic [15:0] prog_len,
    input  logic        prog_byte_valid,
    input  logic [7:0]  prog_byte,
    output logic        prog_busy,
    output logic        prog_done,
    output logic        prog_err,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data
);

    imem_ld_state_t r_state;
    logic [31:0]    r_addr;
    logic [15:0]    r_left;
    logic [1:0]     r_lane;
    logic [23:0]    r_bytes;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic w_word_ready;
    logic w_in_range;

    assign w_word_ready = (r_state == LD_LOAD) && prog_byte_valid && (r_lane == 2'd3);
    assign w_in_range   = r_addr < 32'(DEPTH_WORDS);

    // The final byte is forwarded straight into the write word so the strobe
    // fires in the same cycle that lane 3 arrives.
    assign wr_en   = w_word_ready && w_in_range;
    assign wr_addr = r_addr;
    assign wr_data = {prog_byte, r_bytes};

    assign prog_busy = r_busy;
    assign prog_done = r_done;
    assign prog_err  = r_err;

    always_ff @(posedge clk) begin
        if (!start) begin
            r_state <= LD_IDLE;
            r_lane  <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (prog_start) begin
                        if ((prog_base[1:0] != 2'b00) || (prog_len == 16'd0)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= LD_LOAD;
                            r_addr  <= {2'b00, prog_base[31:2]};
                            r_left  <= prog_len;
                            r_lane  <= 2'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                LD_LOAD: begin
                    if (prog_byte_valid) begin
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0:    r_bytes[7:0]   <= prog_byte;
                            2'd1:    r_bytes[15:8]  <= prog_byte;
                            2'd2:    r_bytes[23:16] <= prog_byte;
                            default: ;
                        endcase
                        if (r_lane == 2'd3) begin
                            if (!w_in_range) begin
                                r_err   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= LD_IDLE;
                            end else begin
                                r_addr <= r_addr + 32'd1;
                                r_left <= r_left - 16'd1;
                                if (r_left == 16'd1) begin
                                    r_state <= LD_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                LD_DONE: begin
                    r_state <= LD_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= LD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_memory.sv
// Instruction memory with one-cycle registered fetch of FETCH_W slots and a byte-stream loader.
// Optional macro IMEM_FETCH_WHILE_LOAD_EN: fetch continues during a load, with write-to-read bypass.
module fetch_memory
    import riscv_defines::*;
#(
    parameter int DEPTH_WORDS = IMEM_WORD,
    parameter int FETCH_W     = 1
) (
    input  logic                clk,
    input  logic                start,
    input  logic                stall,
    input  logic [31:0]         pc,
    input  logic                instmisalign,
    output inst_t [FETCH_W-1:0] inst,
    output logic [FETCH_W-1:0]  inst_valid,
    output logic                imemfault,
    input  logic                prog_start,
    input  logic [31:0]         prog_base,
    input  logic [15:0]         prog_len,
    input  logic                prog_byte_valid,
    input  logic [7:0]          prog_byte,
    output logic                prog_busy,
    output logic                prog_done,
    output logic                prog_err
);

    localparam int BANK_DEPTH = DEPTH_WORDS / FETCH_W;
    localparam int IDX_W      = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

    logic              w_wr_en;
    logic [31:0]       w_wr_addr;
    inst_t             w_wr_data;
    logic              w_wr_bank;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_sel;
    logic              w_rd_en;
    logic              w_block;
    logic [31:0]       w_word      [FETCH_W];
    logic [31:0]       w_bank_word [FETCH_W];
    logic [IDX_W-1:0]  w_rd_idx    [FETCH_W];
    inst_t             w_bank_data [FETCH_W];
    logic              w_unused;

    logic [FETCH_W-1:0] r_ok;
    logic               r_fault;
    logic               r_sel;

    imem_loader #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_loader (
        .clk             (clk),
        .start           (start),
        .prog_start      (prog_start),
        .prog_base       (prog_base),
        .prog_len        (prog_len),
        .prog_byte_valid (prog_byte_valid),
        .prog_byte       (prog_byte),
        .prog_busy       (prog_busy),
        .prog_done       (prog_done),
        .prog_err        (prog_err),
        .wr_en           (w_wr_en),
        .wr_addr         (w_wr_addr),
        .wr_data         (w_wr_data)
    );

`ifdef IMEM_FETCH_WHILE_LOAD_EN
    assign w_block = 1'b0;
`else
    assign w_block = prog_busy;
`endif

    assign w_rd_en   = start && !stall;
    assign w_sel     = (FETCH_W == 2) ? pc[2] : 1'b0;
    assign w_wr_bank = (FETCH_W == 2) ? w_wr_addr[0] : 1'b0;
    assign w_wr_idx  = (FETCH_W == 2) ? w_wr_addr[IDX_W:1] : w_wr_addr[IDX_W-1:0];

    // Consecutive words alternate banks, so bank b always serves slot b ^ pc[2].
    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            w_word[k] = {2'b00, pc[31:2]} + 32'(k);
        end
        for (int b = 0; b < FETCH_W; b++) begin
            w_bank_word[b] = w_word[b ^ int'(w_sel)];
            w_rd_idx[b]    = (FETCH_W == 2) ? w_bank_word[b][IDX_W:1] : w_bank_word[b][IDX_W-1:0];
        end
    end

    for (genvar b = 0; b < FETCH_W; b++) begin : g_bank
        inst_t r_mem [BANK_DEPTH];
        inst_t r_rd;
        logic  w_we;

        assign w_we           = w_wr_en && (w_wr_bank == 1'(b));
        assign w_bank_data[b] = r_rd;

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_wr_idx] <= w_wr_data;
            end
            if (w_rd_en) begin
`ifdef IMEM_FETCH_WHILE_LOAD_EN
                if (w_we && (w_wr_idx == w_rd_idx[b])) begin
                    r_rd <= w_wr_data;
                end else begin
                    r_rd <= r_mem[w_rd_idx[b]];
                end
`else
                r_rd <= r_mem[w_rd_idx[b]];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            r_ok    <= '0;
            r_fault <= 1'b0;
            r_sel   <= 1'b0;
        end else if (!stall) begin
            r_sel <= w_sel;
            if (instmisalign || w_block) begin
                r_ok    <= '0;
                r_fault <= 1'b0;
            end else begin
                for (int k = 0; k < FETCH_W; k++) begin
                    r_ok[k] <= w_word[k] < 32'(DEPTH_WORDS);
                end
                r_fault <= !(w_word[0] < 32'(DEPTH_WORDS));
            end
        end
    end

    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            inst[k] = r_ok[k] ? w_bank_data[k ^ int'(r_sel)] : INST_NOP;
        end
    end

    assign inst_valid = r_ok;
    assign imemfault  = r_fault;

    assign w_unused = ^{pc[1:0], w_wr_addr, w_bank_word[0]};

endmodule

// File: tb/tb_fetch_memory.sv
// Scoreboard bench for fetch_memory (FETCH_W=2, DEPTH_WORDS=8) with a queue-based
// reference model of memory contents and the load byte stream.
module tb_fetch_memory;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 8;
`ifdef IMEM_FETCH_WHILE_LOAD_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [1:0][31:0] inst;
        logic [1:0]       v;
        logic [1:0]       known;
        logic             fault;
        logic             busy;
        logic             done;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             s_start = 1'b0, s_stall = 1'b0, s_mis = 1'b0;
    logic [31:0]      s_pc = '0, s_pb = '0;
    logic [15:0]      s_pl = '0;
    logic             s_ps = 1'b0, s_bv = 1'b0;
    logic [7:0]       s_b = '0;
    logic [1:0][31:0] d_inst;
    logic [1:0]       d_valid;
    logic             d_fault, d_busy, d_done, d_err;

    int n_total = 0;
    int n_bad   = 0;

    exp_t        q[$];
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_loading = 0, m_finishing = 0;
    longint      m_addr = 0;
    int          m_left = 0;
    logic [7:0]  m_bytes[$];
    exp_t        m_prev = '0;

    always #5 clk = ~clk;

    fetch_memory #(.DEPTH_WORDS(DEPTH), .FETCH_W(2)) dut (
        .clk             (clk),
        .start           (s_start),
        .stall           (s_stall),
        .pc              (s_pc),
        .instmisalign    (s_mis),
        .inst            (d_inst),
        .inst_valid      (d_valid),
        .imemfault       (d_fault),
        .prog_start      (s_ps),
        .prog_base       (s_pb),
        .prog_len        (s_pl),
        .prog_byte_valid (s_bv),
        .prog_byte       (s_b),
        .prog_busy       (d_busy),
        .prog_done       (d_done),
        .prog_err        (d_err)
    );

    // Expected outputs after the coming clock edge, derived from the current inputs.
    task automatic model();
        exp_t   e;
        bit     busy_now;
        longint w;
        logic [31:0] word;
        busy_now = m_loading || m_finishing;
        if (!s_start) begin
            e = '0;
            e.inst = {NOP, NOP};
            m_loading = 0;
            m_finishing = 0;
            m_bytes.delete();
        end else begin
            e = m_prev;
            e.done = 0;
            e.err  = 0;
            if (m_finishing) begin
                m_finishing = 0;
            end else if (m_loading) begin
                if (s_bv) begin
                    m_bytes.push_back(s_b);
                    if (m_bytes.size() == 4) begin
                        word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        m_bytes.delete();
                        if (m_addr >= DEPTH) begin
                            e.err = 1;
                            m_loading = 0;
                        end else begin
                            m_mem[int'(m_addr)] = word;
                            m_known[int'(m_addr)] = 1;
                            m_addr++;
                            m_left--;
                            if (m_left == 0) begin
                                m_loading = 0;
                                m_finishing = 1;
                                e.done = 1;
                            end
                        end
                    end
                end
            end else if (s_ps) begin
                if (s_pb[1:0] != 2'b00 || s_pl == 16'd0) begin
                    e.err = 1;
                end else begin
                    m_loading = 1;
                    m_addr = longint'(s_pb) / 4;
                    m_left = int'(s_pl);
                    m_bytes.delete();
                end
            end
            if (!s_stall) begin
                if (s_mis || (busy_now && !BYP)) begin
                    e.inst = {NOP, NOP};
                    e.v = 0;
                    e.known = 0;
                    e.fault = 0;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        w = longint'(s_pc) / 4 + k;
                        if (w < DEPTH) begin
                            e.inst[k]  = m_mem[int'(w)];
                            e.known[k] = m_known[int'(w)];
                            e.v[k]     = 1;
                        end else begin
                            e.inst[k]  = NOP;
                            e.known[k] = 0;
                            e.v[k]     = 0;
                        end
                    end
                    e.fault = (longint'(s_pc) / 4) >= DEPTH;
                end
            end
        end
        e.busy = m_loading || m_finishing;
        m_prev = e;
        q.push_back(e);
    endtask

    task automatic cyc();
        model();
        @(negedge clk);
        s_ps = 0;
        s_bv = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_load(input logic [31:0] base, input logic [15:0] len);
        s_ps = 1; s_pb = base; s_pl = len;
        cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_bv = 1; s_b = b;
        cyc();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    if (e.known[k] || !e.v[k])
                        chk($sformatf("inst%0d", k), d_inst[k], e.inst[k]);
                end
                chk("inst_valid", 32'(d_valid), 32'(e.v));
                chk("imemfault", 32'(d_fault), 32'(e.fault));
                chk("prog_busy", 32'(d_busy), 32'(e.busy));
                chk("prog_done", 32'(d_done), 32'(e.done));
                chk("prog_err", 32'(d_err), 32'(e.err));
            end
        end
    end

    initial begin : stim
        logic [7:0] ld38 [8];
        ld38 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

        s_start = 0;
        idle(2);
        s_start = 1;
        idle(1);

        // Basic two-word load, then fetch from 0.
        send_load(32'h0, 16'd2);
        for (int i = 0; i < 8; i++) send_byte(ld38[i]);
        idle(2);
        s_pc = 32'h0;
        idle(2);

        // Fill the rest of memory, probe the end-of-range boundaries.
        send_load(32'h8, 16'd6);
        for (int i = 0; i < 24; i++) send_byte(8'($urandom));
        idle(2);
        s_pc = 32'h1C; idle(1);
        s_pc = 32'h20; idle(1);
        s_pc = 32'hFFFF_FFFC; idle(1);
        s_pc = 32'h18; idle(1);

        // Malformed load requests and a load running off the end.
        send_load(32'h2, 16'd1); idle(2);
        send_load(32'h4, 16'd0); idle(2);
        send_load(32'h1C, 16'd2);
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
        idle(2);
        s_pc = 32'h1C; idle(1);

        // Stall hold while pc moves, then misaligned fetch.
        s_pc = 32'h4; idle(1);
        s_stall = 1;
        for (int i = 0; i < 3; i++) begin s_pc = 32'(i * 8); idle(1); end
        s_stall = 0;
        s_mis = 1; s_pc = 32'h6; idle(2);
        s_mis = 0; s_pc = 32'h8; idle(1);

        // Reset mid-word, then reload the same word.
        send_load(32'hC, 16'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        s_start = 0; idle(1);
        s_start = 1;
        send_byte(8'hCC);
        send_load(32'hC, 16'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(2);
        s_pc = 32'hC; idle(1);

        // Fetch of the word being written in the same cycle.
        send_load(32'h10, 16'd1);
        send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C);
        s_pc = 32'h10;
        send_byte(8'h8D);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s_start = ($urandom_range(0, 299) != 0);
            s_stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 8) s_pc = 32'($urandom_range(0, 11)) * 4;
            else s_pc = $urandom;
            s_mis = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) begin
                s_ps = 1;
                s_pb = 32'($urandom_range(0, 40));
                s_pl = 16'($urandom_range(0, 3));
            end
            s_bv = ($urandom_range(0, 2) != 0);
            s_b  = 8'($urandom);
            cyc();
        end

        s_start = 1; s_stall = 0;
        idle(2);
        @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
